// File: rtl/subservient_wb_loader.sv
// Byte-stream to Wishbone program loader: packs bytes little-endian into 32-bit words
// and writes each word to the SRAM's Wishbone port at an auto-incrementing word address.
module subservient_wb_loader #(
   parameter int depth = 256,
   parameter int aw    = $clog2(depth)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [7:0]    i_dat,
   input  logic          i_vld,
   output logic          o_rdy,
   input  logic          i_flush,
   input  logic          i_clr,
   output logic          o_busy,
   output logic          o_wrap,
   output logic [aw-3:0] o_wb_adr,
   output logic [31:0]   o_wb_dat,
   output logic [3:0]    o_wb_sel,
   output logic          o_wb_we,
   output logic          o_wb_stb,
   input  logic          i_wb_ack
);

   typedef enum logic {FILL, WRITE} state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [2:0]  cnt_nxt;
   logic        xfer;
   logic        wr_go;
   logic [31:0] dat_nxt;
   logic [3:0]  sel_nxt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      xfer    = i_vld & o_rdy;
      cnt_nxt = cnt + {2'b00, xfer};
      dat_nxt = o_wb_dat;
      if (xfer) begin
         case (cnt[1:0])
            2'd0:    dat_nxt[7:0]   = i_dat;
            2'd1:    dat_nxt[15:8]  = i_dat;
            2'd2:    dat_nxt[23:16] = i_dat;
            default: dat_nxt[31:24] = i_dat;
         endcase
      end
      // The byte of this cycle counts first, so a 4th byte plus flush is one full write.
      wr_go = (cnt_nxt == 3'd4) || (i_flush && (cnt_nxt != 3'd0));
      case (cnt_nxt)
         3'd1:    sel_nxt = 4'b0001;
         3'd2:    sel_nxt = 4'b0011;
         3'd3:    sel_nxt = 4'b0111;
         default: sel_nxt = 4'b1111;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= FILL;
         cnt      <= 3'd0;
         o_rdy    <= 1'b0;
         o_busy   <= 1'b0;
         o_wrap   <= 1'b0;
         o_wb_adr <= '0;
         o_wb_dat <= 32'd0;
         o_wb_sel <= 4'd0;
         o_wb_we  <= 1'b0;
         o_wb_stb <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (i_clr) begin
                  cnt      <= 3'd0;
                  o_wb_adr <= '0;
                  o_wrap   <= 1'b0;
                  o_wb_dat <= 32'd0;
                  o_rdy    <= 1'b1;
               end else begin
                  cnt      <= cnt_nxt;
                  o_wb_dat <= dat_nxt;
                  if (wr_go) begin
                     o_wb_sel <= sel_nxt;
                     o_wb_stb <= 1'b1;
                     o_wb_we  <= 1'b1;
                     o_busy   <= 1'b1;
                     o_rdy    <= 1'b0;
                     state    <= WRITE;
                  end else begin
                     o_rdy    <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (i_wb_ack) begin
                  o_wb_stb <= 1'b0;
                  o_wb_we  <= 1'b0;
                  o_busy   <= 1'b0;
                  o_wb_sel <= 4'd0;
                  o_wb_dat <= 32'd0;
                  cnt      <= 3'd0;
                  o_wb_adr <= o_wb_adr + 1'b1;
                  if (&o_wb_adr)
                     o_wrap <= 1'b1;
                  o_rdy    <= 1'b1;
                  state    <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_subservient_wb_loader.sv
// Bench for subservient_wb_loader: random byte streams against a word-packing model,
// with a Wishbone responder that acks after a random delay and records every write.
module tb_subservient_wb_loader;

   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);
   localparam int NW    = DEPTH / 4;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [7:0]    i_dat;
   logic          i_vld;
   logic          o_rdy;
   logic          i_flush;
   logic          i_clr;
   logic          o_busy;
   logic          o_wrap;
   logic [AW-3:0] o_wb_adr;
   logic [31:0]   o_wb_dat;
   logic [3:0]    o_wb_sel;
   logic          o_wb_we;
   logic          o_wb_stb;
   logic          i_wb_ack;

   subservient_wb_loader #(.depth(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_dat(i_dat), .i_vld(i_vld), .o_rdy(o_rdy),
      .i_flush(i_flush), .i_clr(i_clr), .o_busy(o_busy), .o_wrap(o_wrap),
      .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
      .o_wb_we(o_wb_we), .o_wb_stb(o_wb_stb), .i_wb_ack(i_wb_ack)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: pending bytes of the current word, next word address, wrap flag.
   logic [7:0]  pend [4];
   int          pcnt     = 0;
   int          exp_adr  = 0;
   bit          exp_wrap = 1'b0;
   logic [37:0] exp_q[$];
   logic [37:0] obs_q[$];

   bit ack_en = 1'b1;

   function automatic void model_push_word();
      logic [31:0] d = 32'd0;
      logic [3:0]  s = 4'd0;
      for (int i = 0; i < pcnt; i++) begin
         d = d | (32'(pend[i]) << (8 * i));
         s[i] = 1'b1;
      end
      exp_q.push_back({2'(exp_adr), d, s});
      exp_adr = (exp_adr + 1) % NW;
      if (exp_adr == 0) exp_wrap = 1'b1;
      pcnt = 0;
   endfunction

   // Wishbone responder: acks each strobe after 1..4 extra cycles, checks the bus is
   // held stable while waiting and that o_rdy comes back the cycle after the ack.
   initial begin
      logic [37:0] held;
      int wait_n = 0;
      int delay  = 1;
      bit ack_pending = 1'b0;
      i_wb_ack = 1'b0;
      forever begin
         @(negedge i_clk);
         if (ack_pending) begin
            i_wb_ack = 1'b0;
            ack_pending = 1'b0;
            total++;
            if (o_rdy !== 1'b1 || o_wb_stb !== 1'b0 || o_busy !== 1'b0) begin
               bad++;
               $display("FAIL after_ack: rdy=%b stb=%b busy=%b, want rdy=1 stb=0 busy=0",
                        o_rdy, o_wb_stb, o_busy);
            end
         end else if (o_wb_stb === 1'b1 && ack_en && !i_rst) begin
            total++;
            if (o_rdy !== 1'b0 || o_busy !== 1'b1 || o_wb_we !== 1'b1) begin
               bad++;
               $display("FAIL during_write: rdy=%b busy=%b we=%b, want 0 1 1",
                        o_rdy, o_busy, o_wb_we);
            end
            if (wait_n == 0) begin
               held = {o_wb_adr, o_wb_dat, o_wb_sel};
            end else begin
               total++;
               if ({o_wb_adr, o_wb_dat, o_wb_sel} !== held) begin
                  bad++;
                  $display("FAIL bus_stable: got %h, held %h", {o_wb_adr, o_wb_dat, o_wb_sel}, held);
               end
            end
            wait_n++;
            if (wait_n > delay) begin
               i_wb_ack = 1'b1;
               obs_q.push_back({o_wb_adr, o_wb_dat, o_wb_sel});
               ack_pending = 1'b1;
               wait_n = 0;
               delay = $urandom_range(4, 1);
            end
         end else begin
            i_wb_ack = 1'b0;
            wait_n = 0;
         end
      end
   end

   task automatic wait_rdy();
      int k = 0;
      while (o_rdy !== 1'b1 && k < 100) begin
         @(negedge i_clk);
         k++;
      end
      if (k >= 100) begin
         total++;
         bad++;
         $display("FAIL rdy_timeout: rdy=%b after %0d cycles, want 1", o_rdy, k);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit fl);
      bit issued;
      wait_rdy();
      i_dat = b;
      i_vld = 1'b1;
      i_flush = fl;
      pend[pcnt] = b;
      pcnt++;
      issued = (pcnt == 4) || fl;
      if (issued) model_push_word();
      @(negedge i_clk);
      i_vld = 1'b0;
      i_flush = 1'b0;
      total++;
      if (o_wb_stb !== issued) begin
         bad++;
         $display("FAIL stb_latency: stb=%b, want %b", o_wb_stb, issued);
      end
   endtask

   task automatic flush_only();
      bit issued;
      wait_rdy();
      i_flush = 1'b1;
      issued = (pcnt != 0);
      if (issued) model_push_word();
      @(negedge i_clk);
      i_flush = 1'b0;
      total++;
      if (o_wb_stb !== issued) begin
         bad++;
         $display("FAIL flush_stb: stb=%b, want %b", o_wb_stb, issued);
      end
   endtask

   task automatic clear();
      wait_rdy();
      i_clr = 1'b1;
      pcnt = 0;
      exp_adr = 0;
      exp_wrap = 1'b0;
      @(negedge i_clk);
      i_clr = 1'b0;
   endtask

   // Waits until every expected write has been acked and the loader is ready again.
   task automatic drain();
      int k = 0;
      while ((obs_q.size() < exp_q.size() || o_rdy !== 1'b1) && k < 300) begin
         @(negedge i_clk);
         k++;
      end
      if (k >= 300) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: writes seen=%0d, want %0d", obs_q.size(), exp_q.size());
      end
   endtask

   task automatic compare_writes(input string name);
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL %s_count: writes=%0d, want %0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL %s_write%0d: adr/dat/sel=%h, want %h", name, i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_dat = 8'd0; i_vld = 1'b0; i_flush = 1'b0; i_clr = 1'b0;
      #12;
      total++;
      if ({o_rdy, o_busy, o_wrap, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: %h, want all zero",
                  {o_rdy, o_busy, o_wrap, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb});
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      total++;
      if (o_rdy !== 1'b1 || o_wb_adr !== '0 || o_wb_stb !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: rdy=%b adr=%0d stb=%b, want 1 0 0", o_rdy, o_wb_adr, o_wb_stb);
      end
   endtask

   task automatic test_full_word();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      drain();
      compare_writes("full_word");
      total++;
      if (o_wb_adr !== 2'(exp_adr) || exp_adr != 1) begin
         bad++;
         $display("FAIL full_word_adr: adr=%0d, want 1", o_wb_adr);
      end
   endtask

   task automatic test_partial_flush();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      flush_only();
      send_byte(8'hCC, 1'b0);
      send_byte(8'hDD, 1'b0);
      send_byte(8'hEE, 1'b0);
      send_byte(8'hFF, 1'b0);
      drain();
      compare_writes("partial_flush");
   endtask

   task automatic test_empty_flush();
      flush_only();
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         total++;
         if (o_wb_stb !== 1'b0) begin
            bad++;
            $display("FAIL empty_flush_stb: stb=%b, want 0", o_wb_stb);
         end
      end
      total++;
      if (o_wb_adr !== 2'(exp_adr) || obs_q.size() != 0) begin
         bad++;
         $display("FAIL empty_flush_adr: adr=%0d writes=%0d, want %0d 0", o_wb_adr, obs_q.size(), exp_adr);
      end
   endtask

   task automatic test_flush_with_last();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      drain();
      for (int i = 0; i < 4; i++) @(negedge i_clk);
      compare_writes("flush_with_last");
   endtask

   task automatic test_clr_partial();
      send_byte(8'h5A, 1'b0);
      send_byte(8'hA5, 1'b0);
      clear();
      total++;
      if (o_wb_adr !== '0 || o_wrap !== 1'b0) begin
         bad++;
         $display("FAIL clr_state: adr=%0d wrap=%b, want 0 0", o_wb_adr, o_wrap);
      end
      for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 1'b0);
      drain();
      compare_writes("clr_partial");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(9, 0) == 0) flush_only();
         send_byte(8'($urandom), ($urandom_range(4, 0) == 0));
      end
      flush_only();
      drain();
      compare_writes("random");
      total++;
      if (o_wrap !== exp_wrap || o_wb_adr !== 2'(exp_adr)) begin
         bad++;
         $display("FAIL random_state: wrap=%b adr=%0d, want %b %0d", o_wrap, o_wb_adr, exp_wrap, exp_adr);
      end
   endtask

   task automatic test_wrap();
      clear();
      for (int w = 0; w < 5; w++) begin
         for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
         drain();
         total++;
         if (o_wrap !== exp_wrap || o_wb_adr !== 2'(exp_adr) || exp_wrap != (w >= 3)) begin
            bad++;
            $display("FAIL wrap_word%0d: wrap=%b adr=%0d, want %b %0d", w, o_wrap, o_wb_adr,
                     (w >= 3), (w + 1) % NW);
         end
      end
      compare_writes("wrap");
      clear();
      total++;
      if (o_wrap !== 1'b0 || o_wb_adr !== '0) begin
         bad++;
         $display("FAIL wrap_clr: wrap=%b adr=%0d, want 0 0", o_wrap, o_wb_adr);
      end
   endtask

   task automatic test_reset_mid_write();
      ack_en = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
      @(negedge i_clk);
      total++;
      if (o_wb_stb !== 1'b1) begin
         bad++;
         $display("FAIL mid_write_stb: stb=%b, want 1", o_wb_stb);
      end
      i_rst = 1'b1;
      #1;
      total++;
      if (o_wb_stb !== 1'b0 || o_busy !== 1'b0 || o_rdy !== 1'b0 || o_wb_we !== 1'b0) begin
         bad++;
         $display("FAIL mid_write_reset: stb=%b busy=%b rdy=%b we=%b, want 0 0 0 0",
                  o_wb_stb, o_busy, o_rdy, o_wb_we);
      end
      exp_q.delete();
      obs_q.delete();
      pcnt = 0; exp_adr = 0; exp_wrap = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      ack_en = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      total++;
      if (o_rdy !== 1'b1 || o_wb_adr !== '0 || o_wb_stb !== 1'b0) begin
         bad++;
         $display("FAIL mid_write_release: rdy=%b adr=%0d stb=%b, want 1 0 0", o_rdy, o_wb_adr, o_wb_stb);
      end
      for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), 1'b0);
      flush_only();
      drain();
      compare_writes("after_reset");
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial_flush();
      test_empty_flush();
      test_flush_with_last();
      test_clr_partial();
      test_random();
      test_wrap();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
